wr_slave_arb: RTL and testbench
===============================

# wr_slave_arb

Per-slave write-channel arbiter for the two-master / two-slave AXI interconnect. Decodes each master's AWADDR against this slave's address window, grants the write path to one master with round-robin fairness, and holds the grant across the AW, W and B phases until the write response has been accepted. Its `mas_sel` output is the per-slave master-select consumed by the write-path muxes and by the slave-return logic, which routes AWREADY, WREADY, BVALID and BRESP back to the granted master. One instance is placed per slave; their outputs form `mas_sel1` and `mas_sel2`.

## Interface

Clocking and reset: single clock `ACLK`; reset `ARESET` is synchronous and active-high.

Parameters:
- `ADDR_W`, 32: AWADDR width.
- `SLV_BASE`, 32'h0000_0000: slave window base.
- `SLV_MASK`, 32'hF000_0000: decode mask. A request hits when `(AWADDR & SLV_MASK) == SLV_BASE`.
- `TIMEOUT`, 256: watchdog limit in cycles. Used only with the macro.

Ports:
- `ACLK` in 1: clock.
- `ARESET` in 1: synchronous active-high reset.
- `m1_AWVALID`, `m2_AWVALID` in 1: master write-address valid.
- `m1_AWADDR`, `m2_AWADDR` in ADDR_W: master write address.
- `m1_WVALID`, `m2_WVALID` in 1: master write-data valid.
- `m1_WLAST`, `m2_WLAST` in 1: master last beat.
- `m1_BREADY`, `m2_BREADY` in 1: master response ready.
- `s_AWREADY`, `s_WREADY`, `s_BVALID` in 1: slave handshake signals.
- `mas_sel` out 2: 2'b01 = master 1 granted, 2'b10 = master 2 granted, 2'b00 = none. 2'b11 is never driven.
- `aw_en`, `w_en`, `b_en` out 1: phase enables that gate the AW, W and B muxes.
- `err` out 1: one-cycle pulse when the watchdog aborts a transaction.

## Operation

- Request: `reqN = mN_AWVALID & addr_hit(mN_AWADDR)`.
- FSM states: IDLE, ADDR, DATA, RESP.
  - IDLE: with no request, stay in IDLE. With one request, grant that master. With both requesting, grant the master that was not granted most recently (`last_gnt`). On a grant, register `mas_sel` and go to ADDR.
  - ADDR: `aw_en`=1. On a granted AWVALID & `s_AWREADY` handshake, go to DATA.
  - DATA: `w_en`=1. On a granted WVALID & `s_WREADY` & WLAST handshake, go to RESP. Non-last beats stay in DATA. W is never forwarded before AW is accepted.
  - RESP: `b_en`=1. On `s_BVALID` & granted BREADY, go to IDLE, clear `mas_sel`, and set `last_gnt` to the master just served.
- Phase enables are decoded from the current state (Moore outputs). At most one of `aw_en`, `w_en`, `b_en` is high, and all are 0 in IDLE.
- A request that drops while the FSM is in ADDR does not release the grant.
- Requests from the non-granted master are ignored until the FSM returns to IDLE.

## Timing

- Reset values: `mas_sel`=2'b00, `aw_en`=`w_en`=`b_en`=0, `err`=0, state=IDLE, `last_gnt`=master 2 (so master 1 wins the first tie).
- Reset mid-transaction drops to IDLE on the next edge. No response is generated.
- Grant latency: a request sampled in IDLE at edge N gives `mas_sel` valid and `aw_en`=1 after edge N. The first possible AW handshake is in cycle N+1.
- Each phase transition takes effect on the edge that samples the handshake.
- Minimum single-beat transaction: IDLE → ADDR → DATA → RESP → IDLE, 4 cycles.
- Back-to-back transactions: after RESP exits, there is 1 IDLE cycle before the next grant.

## Configuration

- `WR_ARB_TIMEOUT_EN` defined:
  - A counter clears on every state change and on every W beat handshake.
  - If it reaches TIMEOUT−1 while the FSM is in ADDR, DATA or RESP, the FSM forces IDLE, clears `mas_sel`, pulses `err` for 1 cycle and updates `last_gnt`.
  - Counter width is `$clog2(TIMEOUT)`.
- `WR_ARB_TIMEOUT_EN` undefined: no counter is built, `err` is tied to 0, and the arbiter waits indefinitely.

## Test plan

- Reset, then `m1_AWVALID`=1 with AWADDR=32'h0000_0100 (hit) → `mas_sel`=01 next cycle; AW, W (WLAST) and B handshakes with 1-cycle readies → `mas_sel` returns to 00 after 4 cycles.
- Both masters request hitting addresses in the same cycle after reset → master 1 served first (01); master 2 granted (10) 1 cycle after master 1's B handshake.
- `m2_AWADDR`=32'h1000_0000 with default parameters → no grant, `mas_sel` stays 00.
- 4-beat burst with `s_WREADY` toggling → FSM stays in DATA until the WLAST handshake; `b_en` rises only after it.
- `ARESET` asserted in DATA → next cycle `mas_sel`=00 and all enables 0.
- With `WR_ARB_TIMEOUT_EN` and TIMEOUT=8, `s_BVALID` held at 0 in RESP → after 8 cycles in RESP, `err` pulses for one cycle and `mas_sel`=00; without the macro, `err` stays 0 and the grant is held.

Source files
------------

// File: rtl/wr_slave_arb.sv
// -----------------------------------------------------------------------------
// wr_slave_arb
//
// Write-channel arbiter for one slave of the two-master / two-slave AXI
// interconnect. Each master's AWADDR is decoded against this slave's window.
// The write path is granted to one master with round-robin fairness, and the
// grant is held across the AW, W and B phases until the write response has
// been accepted.
//
// Handshake rule: a phase advances only on a cycle where the granted master's
// VALID (or BREADY) and the slave's READY (or BVALID) are both high at the
// rising edge of ACLK. Signals from the non-granted master are ignored.
//
// Optional feature macro: WR_ARB_TIMEOUT_EN
//   defined   : a watchdog aborts a transaction stuck for TIMEOUT cycles in
//               one phase and pulses err for one cycle.
//   undefined : no watchdog is built, err is tied low, waits are unbounded.
//
// Ports
//   ACLK, ARESET               clock, synchronous active-high reset
//   m1_/m2_AWVALID, _AWADDR    master write-address request
//   m1_/m2_WVALID, _WLAST      master write data valid / last beat
//   m1_/m2_BREADY              master write-response ready
//   s_AWREADY, s_WREADY,
//   s_BVALID                   slave handshake inputs
//   mas_sel                    01 = master 1, 10 = master 2, 00 = none
//   aw_en, w_en, b_en          phase enables for the AW, W and B muxes
//   err                        one-cycle watchdog abort pulse
//   dbg_state_o                FSM state: 0 IDLE, 1 ADDR, 2 DATA, 3 RESP
// -----------------------------------------------------------------------------
module wr_slave_arb #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] SLV_BASE = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] SLV_MASK = 32'hF000_0000,
  parameter int                TIMEOUT  = 256
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              m1_AWVALID,
  input  logic              m2_AWVALID,
  input  logic [ADDR_W-1:0] m1_AWADDR,
  input  logic [ADDR_W-1:0] m2_AWADDR,
  input  logic              m1_WVALID,
  input  logic              m2_WVALID,
  input  logic              m1_WLAST,
  input  logic              m2_WLAST,
  input  logic              m1_BREADY,
  input  logic              m2_BREADY,
  input  logic              s_AWREADY,
  input  logic              s_WREADY,
  input  logic              s_BVALID,
  output logic [1:0]        mas_sel,
  output logic              aw_en,
  output logic              w_en,
  output logic              b_en,
  output logic              err,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] mas_sel_q, mas_sel_d;
  // 1 = master 2 was served most recently, 0 = master 1.
  logic       last_m2_q, last_m2_d;

  logic req1, req2;
  logic g_awvalid, g_wvalid, g_wlast, g_bready;
  logic w_hs;
  logic timeout;

  assign req1 = m1_AWVALID & ((m1_AWADDR & SLV_MASK) == SLV_BASE);
  assign req2 = m2_AWVALID & ((m2_AWADDR & SLV_MASK) == SLV_BASE);

  // Granted-master views; mas_sel_q is one-hot whenever the FSM is busy.
  assign g_awvalid = mas_sel_q[1] ? m2_AWVALID : (mas_sel_q[0] & m1_AWVALID);
  assign g_wvalid  = mas_sel_q[1] ? m2_WVALID  : (mas_sel_q[0] & m1_WVALID);
  assign g_wlast   = mas_sel_q[1] ? m2_WLAST   : (mas_sel_q[0] & m1_WLAST);
  assign g_bready  = mas_sel_q[1] ? m2_BREADY  : (mas_sel_q[0] & m1_BREADY);

  assign w_hs = (state_q == S_DATA) & g_wvalid & s_WREADY;

  always_comb begin
    state_d   = state_q;
    mas_sel_d = mas_sel_q;
    last_m2_d = last_m2_q;
    case (state_q)
      S_IDLE: begin
        // On a tie the master not served last wins.
        if (req1 && (!req2 || last_m2_q)) begin
          mas_sel_d = 2'b01;
          state_d   = S_ADDR;
        end else if (req2) begin
          mas_sel_d = 2'b10;
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (g_awvalid && s_AWREADY) state_d = S_DATA;
      end
      S_DATA: begin
        if (w_hs && g_wlast) state_d = S_RESP;
      end
      S_RESP: begin
        if (s_BVALID && g_bready) begin
          state_d   = S_IDLE;
          mas_sel_d = 2'b00;
          last_m2_d = mas_sel_q[1];
        end
      end
      default: begin
        state_d   = S_IDLE;
        mas_sel_d = 2'b00;
      end
    endcase
    // Watchdog abort overrides any handshake in the same cycle.
    if (timeout) begin
      state_d   = S_IDLE;
      mas_sel_d = 2'b00;
      last_m2_d = mas_sel_q[1];
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= S_IDLE;
      mas_sel_q <= 2'b00;
      last_m2_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      mas_sel_q <= mas_sel_d;
      last_m2_q <= last_m2_d;
    end
  end

`ifdef WR_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // Counts cycles spent in one phase without progress; any state change or
  // W beat restarts it.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= timeout;
      if ((state_d != state_q) || w_hs || (state_q == S_IDLE)) cnt_q <= '0;
      else                                                      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign timeout = (state_q != S_IDLE) && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign err     = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign timeout        = 1'b0;
  assign err            = 1'b0;
`endif

  assign mas_sel     = mas_sel_q;
  assign aw_en       = (state_q == S_ADDR);
  assign w_en        = (state_q == S_DATA);
  assign b_en        = (state_q == S_RESP);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wr_slave_arb.sv
// -----------------------------------------------------------------------------
// tb_wr_slave_arb
//
// Directed-vector bench for wr_slave_arb. Inputs are driven and outputs are
// sampled 1 ns after each rising edge. Expected values are hand-derived.
// Built with WR_ARB_TIMEOUT_EN the DUT watchdog (TIMEOUT=8) is exercised;
// without it, the bench checks that a stalled response holds the grant.
// -----------------------------------------------------------------------------
module tb_wr_slave_arb;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic areset;

  logic        m1_awvalid, m2_awvalid;
  logic [31:0] m1_awaddr, m2_awaddr;
  logic        m1_wvalid, m2_wvalid, m1_wlast, m2_wlast;
  logic        m1_bready, m2_bready;
  logic        s_awready, s_wready, s_bvalid;
  logic [1:0]  mas_sel;
  logic        aw_en, w_en, b_en, err;
  logic [1:0]  dbg_state;

  wr_slave_arb #(
    .ADDR_W  (32),
    .SLV_BASE(32'h0000_0000),
    .SLV_MASK(32'hF000_0000),
    .TIMEOUT (8)
  ) dut (
    .ACLK       (clk),
    .ARESET     (areset),
    .m1_AWVALID (m1_awvalid),
    .m2_AWVALID (m2_awvalid),
    .m1_AWADDR  (m1_awaddr),
    .m2_AWADDR  (m2_awaddr),
    .m1_WVALID  (m1_wvalid),
    .m2_WVALID  (m2_wvalid),
    .m1_WLAST   (m1_wlast),
    .m2_WLAST   (m2_wlast),
    .m1_BREADY  (m1_bready),
    .m2_BREADY  (m2_bready),
    .s_AWREADY  (s_awready),
    .s_WREADY   (s_wready),
    .s_BVALID   (s_bvalid),
    .mas_sel    (mas_sel),
    .aw_en      (aw_en),
    .w_en       (w_en),
    .b_en       (b_en),
    .err        (err),
    .dbg_state_o(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Checks state, grant, phase enables and err against expectations.
  task automatic chk(input string tag, input logic [1:0] st, input logic [1:0] sel,
                     input logic exp_err);
    logic [2:0] exp_en;
    exp_en = {st == ST_ADDR, st == ST_DATA, st == ST_RESP};
    check({tag, "/state"}, 32'(dbg_state), 32'(st));
    check({tag, "/sel"}, 32'(mas_sel), 32'(sel));
    check({tag, "/en"}, 32'({aw_en, w_en, b_en}), 32'(exp_en));
    check({tag, "/err"}, 32'(err), 32'(exp_err));
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m1_awvalid = 0; m2_awvalid = 0;
    m1_awaddr  = 32'h0; m2_awaddr = 32'h0;
    m1_wvalid  = 0; m2_wvalid = 0; m1_wlast = 0; m2_wlast = 0;
    m1_bready  = 0; m2_bready = 0;
    s_awready  = 0; s_wready = 0; s_bvalid = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    areset = 1;
    tick();
    tick();
    areset = 0;
  endtask

  task automatic set_aw(input int m, input logic v);
    if (m == 1) m1_awvalid = v; else m2_awvalid = v;
  endtask

  task automatic set_w(input int m, input logic v);
    if (m == 1) begin m1_wvalid = v; m1_wlast = v; end
    else        begin m2_wvalid = v; m2_wlast = v; end
  endtask

  task automatic set_b(input int m, input logic v);
    if (m == 1) m1_bready = v; else m2_bready = v;
  endtask

  // From ADDR with master m granted: AW, single W (last), B.
  task automatic do_txn(input int m, input string tag);
    logic [1:0] sel;
    sel = (m == 1) ? 2'b01 : 2'b10;
    set_aw(m, 1); s_awready = 1;
    tick(); chk({tag, "_aw"}, ST_DATA, sel, 0);
    set_aw(m, 0); s_awready = 0; set_w(m, 1); s_wready = 1;
    tick(); chk({tag, "_w"}, ST_RESP, sel, 0);
    set_w(m, 0); s_wready = 0; set_b(m, 1); s_bvalid = 1;
    tick(); chk({tag, "_b"}, ST_IDLE, 2'b00, 0);
    set_b(m, 0); s_bvalid = 0;
  endtask

  initial begin
    // --- reset state
    clear_inputs();
    areset = 1;
    tick();
    tick();
    chk("rst", ST_IDLE, 2'b00, 0);
    areset = 0;
    tick();
    chk("rst_idle", ST_IDLE, 2'b00, 0);

    // --- single transaction from master 1
    m1_awaddr = 32'h0000_0100; m1_awvalid = 1;
    tick(); chk("t1_grant", ST_ADDR, 2'b01, 0);
    do_txn(1, "t1");
    tick(); chk("t1_after", ST_IDLE, 2'b00, 0);

    // --- tie after reset: master 1 first, then master 2
    do_reset();
    m1_awaddr = 32'h0000_0100; m2_awaddr = 32'h0000_0200;
    m1_awvalid = 1; m2_awvalid = 1;
    tick(); chk("tie_m1", ST_ADDR, 2'b01, 0);
    do_txn(1, "tie_m1");
    tick(); chk("tie_m2", ST_ADDR, 2'b10, 0);
    s_awready = 1;
    tick(); chk("m2_aw", ST_DATA, 2'b10, 0);
    m2_awvalid = 0; s_awready = 0;
    // master 1 W beat must not move master 2's transaction
    m1_wvalid = 1; m1_wlast = 1; s_wready = 1;
    tick(); chk("m2_ign_w", ST_DATA, 2'b10, 0);
    m1_wvalid = 0; m1_wlast = 0; m2_wvalid = 1; m2_wlast = 1;
    tick(); chk("m2_w", ST_RESP, 2'b10, 0);
    m2_wvalid = 0; m2_wlast = 0; s_wready = 0;
    m1_bready = 1; s_bvalid = 1;
    tick(); chk("m2_ign_b", ST_RESP, 2'b10, 0);
    m1_bready = 0; m2_bready = 1;
    tick(); chk("m2_b", ST_IDLE, 2'b00, 0);
    m2_bready = 0; s_bvalid = 0;

    // --- round robin: last served m2 -> m1 wins tie, then m2 wins next tie
    m1_awvalid = 1; m2_awvalid = 1;
    tick(); chk("rr_m1", ST_ADDR, 2'b01, 0);
    do_txn(1, "rr_m1");
    m1_awvalid = 1; m2_awvalid = 1;
    tick(); chk("rr_m2", ST_ADDR, 2'b10, 0);
    m1_awvalid = 0;
    do_txn(2, "rr_m2");

    // --- address miss: no grant
    do_reset();
    m2_awaddr = 32'h1000_0000; m2_awvalid = 1;
    m1_awaddr = 32'hF000_0100; m1_awvalid = 1;
    tick(); chk("miss1", ST_IDLE, 2'b00, 0);
    tick(); chk("miss2", ST_IDLE, 2'b00, 0);
    m1_awaddr = 32'h0FFF_FFFC;
    tick(); chk("edge_hit", ST_ADDR, 2'b01, 0);
    m2_awvalid = 0;

    // --- dropped request in ADDR keeps grant; burst with gaps
    m1_awvalid = 0;
    tick(); chk("addr_drop", ST_ADDR, 2'b01, 0);
    s_awready = 1;
    tick(); chk("addr_nohs", ST_ADDR, 2'b01, 0);
    m1_awvalid = 1;
    tick(); chk("burst_aw", ST_DATA, 2'b01, 0);
    m1_awvalid = 0; s_awready = 0;
    m1_wvalid = 1; s_wready = 1;
    tick(); chk("beat1", ST_DATA, 2'b01, 0);
    s_wready = 0;
    tick(); chk("beat2_wait", ST_DATA, 2'b01, 0);
    s_wready = 1;
    tick(); chk("beat2", ST_DATA, 2'b01, 0);
    tick(); chk("beat3", ST_DATA, 2'b01, 0);
    m1_wlast = 1; s_wready = 0;
    tick(); chk("beat4_wait", ST_DATA, 2'b01, 0);
    s_wready = 1;
    tick(); chk("beat4", ST_RESP, 2'b01, 0);
    m1_wvalid = 0; m1_wlast = 0; s_wready = 0;
    s_bvalid = 1; m1_bready = 1;
    tick(); chk("burst_b", ST_IDLE, 2'b00, 0);
    s_bvalid = 0; m1_bready = 0;

    // --- reset while in DATA
    m1_awvalid = 1;
    tick(); chk("rd_grant", ST_ADDR, 2'b01, 0);
    s_awready = 1;
    tick(); chk("rd_data", ST_DATA, 2'b01, 0);
    m1_awvalid = 0; s_awready = 0;
    areset = 1;
    tick(); chk("rd_reset", ST_IDLE, 2'b00, 0);
    areset = 0;

    // --- stalled response
    m1_awvalid = 1;
    tick(); chk("st_grant", ST_ADDR, 2'b01, 0);
    do_txn_stall();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Drives master 1 into RESP and holds s_BVALID low.
  task automatic do_txn_stall();
    s_awready = 1;
    tick(); chk("st_aw", ST_DATA, 2'b01, 0);
    m1_awvalid = 0; s_awready = 0; m1_wvalid = 1; m1_wlast = 1; s_wready = 1;
    tick(); chk("st_resp", ST_RESP, 2'b01, 0);
    m1_wvalid = 0; m1_wlast = 0; s_wready = 0; m1_bready = 1;
`ifdef WR_ARB_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      tick(); chk("st_hold", ST_RESP, 2'b01, 0);
    end
    tick(); chk("st_abort", ST_IDLE, 2'b00, 1);
    m1_bready = 0;
    tick(); chk("st_err_low", ST_IDLE, 2'b00, 0);
    // aborted master counts as served: master 2 wins the next tie
    m1_awvalid = 1; m2_awvalid = 1; m2_awaddr = 32'h0000_0040;
    tick(); chk("st_rr", ST_ADDR, 2'b10, 0);
    m1_awvalid = 0;
    do_txn(2, "st_m2");
`else
    for (int i = 0; i < 20; i++) begin
      tick(); chk("st_hold", ST_RESP, 2'b01, 0);
    end
    s_bvalid = 1;
    tick(); chk("st_b", ST_IDLE, 2'b00, 0);
    s_bvalid = 0; m1_bready = 0;
`endif
  endtask

endmodule
